// File: rtl/gsm_tx_arbiter.sv
// ---------------------------------------------------------------------------
// gsm_tx_arbiter
//
// Lets three AT-command sources share the one GSM UART transmitter. One source
// at a time owns the line for a whole command transaction. Its bytes go to the
// UART one at a time, and it gets a per-byte completion pulse back. An idle
// guard gap separates owners, and a watchdog revokes an owner that stalls.
//
// Ports
//   clk            system clock
//   rst_n          synchronous, active-low reset
//   req[2:0]       level request per source: [0]=SMS [1]=dial [2]=answer
//   byte_en[2:0]   1-cycle strobe, source i presents a byte on its lane
//   byte_data[23:0]{d2,d1,d0}; lane i = byte_data[8*i+7:8*i]
//   grant[2:0]     one-hot (or zero) current owner, registered
//   byte_done[2:0] 1-cycle pulse to the owner once its byte has left the UART
//   busy           high whenever the arbiter is not idle
//   timeout_err    1-cycle pulse when the watchdog revokes an owner
//   uart_tx_enable level to the UART tx_enable / baud cnt_start, one byte long
//   uart_tx_data   byte to the UART, stable while uart_tx_enable is high
//   uart_tx_done   UART byte-complete pulse
// ---------------------------------------------------------------------------
module gsm_tx_arbiter #(
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned CNT_W          = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [2:0]  byte_en,
  input  logic [23:0] byte_data,
  output logic [2:0]  grant,
  output logic [2:0]  byte_done,
  output logic        busy,
  output logic        timeout_err,
  output logic        uart_tx_enable,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_done
);

  typedef enum logic [1:0] {IDLE, OWN, SEND, GUARD} state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       byte_done_q, byte_done_d;
  logic             timeout_q, timeout_d;
  logic             en_q, en_d;
  logic [7:0]       data_q, data_d;
  // Owner dropped req in the same cycle it strobed a byte: finish that byte,
  // then release instead of returning to OWN.
  logic             pend_q, pend_d;

  logic       ownerReq;
  logic       ownerStrobe;
  logic [7:0] laneData;
  logic [2:0] pickGrant;

  // Owner-relative views of the request inputs. Because grant is one-hot,
  // a strobe or request from a non-owner masks to zero here.
  assign ownerReq    = |(req & grant_q);
  assign ownerStrobe = |(byte_en & grant_q);

  // Fixed priority: answer > dial > SMS.
  always_comb begin
    pickGrant = 3'b000;
    if (req[2])      pickGrant = 3'b100;
    else if (req[1]) pickGrant = 3'b010;
    else if (req[0]) pickGrant = 3'b001;
  end

  // Data lane of the current owner.
  always_comb begin
    laneData = 8'h00;
    if (grant_q[2])      laneData = byte_data[23:16];
    else if (grant_q[1]) laneData = byte_data[15:8];
    else if (grant_q[0]) laneData = byte_data[7:0];
  end

  // Next-state logic. A single counter serves as watchdog in OWN/SEND and as
  // the gap timer in GUARD. It is cleared on every state change.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    grant_d     = grant_q;
    byte_done_d = 3'b000;
    timeout_d   = 1'b0;
    en_d        = en_q;
    data_d      = data_q;
    pend_d      = pend_q;

    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        en_d    = 1'b0;
        grant_d = 3'b000;
        pend_d  = 1'b0;
        if (|req) begin
          grant_d = pickGrant;
          state_d = OWN;
        end
      end

      OWN: begin
        if (ownerStrobe) begin
          data_d  = laneData;
          en_d    = 1'b1;
          cnt_d   = '0;
          pend_d  = ~ownerReq;
          state_d = SEND;
        end else if (!ownerReq) begin
          grant_d = 3'b000;
          cnt_d   = '0;
          state_d = GUARD;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          grant_d   = 3'b000;
          cnt_d     = '0;
          state_d   = GUARD;
        end
      end

      SEND: begin
        if (uart_tx_done) begin
          en_d        = 1'b0;
          byte_done_d = grant_q;
          cnt_d       = '0;
          pend_d      = 1'b0;
          if (ownerReq && !pend_q) begin
            state_d = OWN;
          end else begin
            grant_d = 3'b000;
            state_d = GUARD;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          en_d      = 1'b0;
          timeout_d = 1'b1;
          grant_d   = 3'b000;
          cnt_d     = '0;
          pend_d    = 1'b0;
          state_d   = GUARD;
        end
      end

      GUARD: begin
        en_d    = 1'b0;
        grant_d = 3'b000;
        if (cnt_q == GUARD_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= 3'b000;
      byte_done_q <= 3'b000;
      timeout_q   <= 1'b0;
      en_q        <= 1'b0;
      data_q      <= 8'h00;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      byte_done_q <= byte_done_d;
      timeout_q   <= timeout_d;
      en_q        <= en_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
    end
  end

  assign grant          = grant_q;
  assign byte_done      = byte_done_q;
  assign timeout_err    = timeout_q;
  assign uart_tx_enable = en_q;
  assign uart_tx_data   = data_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_gsm_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gsm_tx_arbiter
//
// Directed bench for gsm_tx_arbiter with GUARD_CYCLES=4 and TIMEOUT_CYCLES=100.
// A small UART model answers each byte 20 clocks after tx_enable rises. Bytes
// that should reach the UART are pushed to a queue when they are strobed, and
// they are popped and compared when the DUT raises uart_tx_enable.
// ---------------------------------------------------------------------------
module tb_gsm_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  byte_en;
  logic [23:0] byte_data;
  logic [2:0]  grant;
  logic [2:0]  byte_done;
  logic        busy;
  logic        timeout_err;
  logic        uart_tx_enable;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_done;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] expQ[$];
  int         doneCount[3];
  int         timeoutCount;
  logic       prevEn;
  bit         uartHang;

  gsm_tx_arbiter #(
    .GUARD_CYCLES  (4),
    .TIMEOUT_CYCLES(100),
    .CNT_W         (26)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .byte_en       (byte_en),
    .byte_data     (byte_data),
    .grant         (grant),
    .byte_done     (byte_done),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .uart_tx_enable(uart_tx_enable),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_done  (uart_tx_done)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so a stuck run still ends with a report.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  // Single comparison point: counts and reports through an immediate assertion.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge. Inputs driven here are
  // sampled at the following edge, and outputs read here are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one byte on a lane for one cycle. The byte is queued as expected
  // UART traffic only when the bench knows that lane owns the line.
  task automatic applyStimulus(input int lane, input logic [7:0] d, input bit accepted);
    byte_en               = 3'b000;
    byte_en[lane]         = 1'b1;
    byte_data             = 24'h0;
    byte_data[8*lane +: 8] = d;
    if (accepted) expQ.push_back(d);
    tick();
    byte_en = 3'b000;
    checkOutput($sformatf("tx_enable_after_strobe_lane%0d", lane), {31'd0, uart_tx_enable}, {31'd0, accepted});
  endtask

  // Wait, within a cycle budget, for the byte_done pulse on one lane.
  task automatic waitByteDone(input int lane);
    bit found = 0;
    int n = 0;
    while (!found && n < 60) begin
      tick();
      n++;
      if (byte_done[lane]) found = 1;
    end
    checkOutput($sformatf("byte_done_lane%0d_seen", lane), {31'd0, found}, 32'd1);
  endtask

  // UART model: once tx_enable is seen, wait 20 clocks and pulse done for one
  // cycle. If tx_enable falls early (reset, watchdog) the byte is abandoned.
  initial begin
    uart_tx_done = 1'b0;
    forever begin
      tick();
      if (uart_tx_enable === 1'b1 && !uartHang) begin
        for (int k = 0; k < 20; k++) begin
          tick();
          if (uart_tx_enable !== 1'b1) break;
        end
        if (uart_tx_enable === 1'b1) begin
          uart_tx_done = 1'b1;
          tick();
          uart_tx_done = 1'b0;
        end
      end
    end
  end

  // Scoreboard and protocol monitor on the falling edge. Each new byte on the
  // UART must match the oldest queued byte. Pulses are counted per lane, and
  // byte_done must never coincide with timeout_err.
  always @(negedge clk) begin
    if (uart_tx_enable === 1'b1 && prevEn !== 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_uart_byte", {24'd0, uart_tx_data}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("uart_tx_data", {24'd0, uart_tx_data}, {24'd0, expQ.pop_front()});
      end
    end
    if ((|byte_done === 1'b1) || (timeout_err === 1'b1)) begin
      checkOutput("done_timeout_exclusive", {31'd0, (|byte_done) & timeout_err}, 32'd0);
    end
    for (int i = 0; i < 3; i++) if (byte_done[i] === 1'b1) doneCount[i]++;
    if (timeout_err === 1'b1) timeoutCount++;
    prevEn = uart_tx_enable;
  end

  // Directed sequence.
  initial begin
    rst_n        = 1'b0;
    req          = 3'b000;
    byte_en      = 3'b000;
    byte_data    = 24'h0;
    uartHang     = 1'b0;
    timeoutCount = 0;
    for (int i = 0; i < 3; i++) doneCount[i] = 0;

    // Reset state.
    repeat (3) tick();
    checkOutput("reset_grant", {29'd0, grant}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_tx_enable", {31'd0, uart_tx_enable}, 32'd0);
    checkOutput("reset_tx_data", {24'd0, uart_tx_data}, 32'd0);
    checkOutput("reset_byte_done", {29'd0, byte_done}, 32'd0);
    checkOutput("reset_timeout", {31'd0, timeout_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // SMS sends "AT\r" and then releases; the guard gap lasts 4 clocks.
    req = 3'b001;
    tick();
    checkOutput("sms_grant", {29'd0, grant}, 32'h1);
    checkOutput("sms_busy", {31'd0, busy}, 32'd1);
    applyStimulus(0, 8'h41, 1); waitByteDone(0);
    applyStimulus(0, 8'h54, 1); waitByteDone(0);
    applyStimulus(0, 8'h0D, 1); waitByteDone(0);
    checkOutput("sms_grant_held", {29'd0, grant}, 32'h1);
    req = 3'b000;
    tick();
    checkOutput("sms_release_grant", {29'd0, grant}, 32'd0);
    repeat (3) tick();
    checkOutput("guard_busy_3", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("guard_done_idle", {31'd0, busy}, 32'd0);

    // All three request at once; answer wins, and non-owner strobes are dropped.
    req = 3'b111;
    tick();
    checkOutput("prio_grant_answer", {29'd0, grant}, 32'h4);
    applyStimulus(0, 8'h11, 0);
    applyStimulus(1, 8'h22, 0);
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    checkOutput("stray_done_ignored", {29'd0, byte_done}, 32'd0);
    applyStimulus(2, 8'h0A, 1); waitByteDone(2);
    req = 3'b011;
    tick();
    checkOutput("answer_release_grant", {29'd0, grant}, 32'd0);
    repeat (4) tick();
    checkOutput("gap_before_dial", {29'd0, grant}, 32'd0);
    tick();
    checkOutput("prio_grant_dial", {29'd0, grant}, 32'h2);
    req = 3'b001;
    tick();
    repeat (4) tick();
    tick();
    checkOutput("prio_grant_sms", {29'd0, grant}, 32'h1);
    req = 3'b000;
    tick();
    repeat (4) tick();
    checkOutput("prio_idle", {31'd0, busy}, 32'd0);

    // No preemption: dial requests while SMS is mid-byte.
    req = 3'b001;
    tick();
    applyStimulus(0, 8'h2B, 1);
    req = 3'b011;
    waitByteDone(0);
    checkOutput("no_preempt_after_done", {29'd0, grant}, 32'h1);
    tick();
    checkOutput("no_preempt_next", {29'd0, grant}, 32'h1);
    req = 3'b010;
    tick();
    repeat (4) tick();
    tick();
    checkOutput("dial_after_sms", {29'd0, grant}, 32'h2);
    // Strobe and release in the same cycle: the byte still goes out, then release.
    req = 3'b000;
    applyStimulus(1, 8'h2C, 1);
    waitByteDone(1);
    checkOutput("late_release_grant", {29'd0, grant}, 32'd0);
    checkOutput("late_release_busy", {31'd0, busy}, 32'd1);
    repeat (4) tick();
    checkOutput("late_release_idle", {31'd0, busy}, 32'd0);

    // Owner goes quiet: revoked after 100 clocks.
    req = 3'b001;
    tick();
    repeat (99) tick();
    checkOutput("own_wd_not_yet", {31'd0, timeout_err}, 32'd0);
    checkOutput("own_wd_grant_held", {29'd0, grant}, 32'h1);
    tick();
    checkOutput("own_wd_pulse", {31'd0, timeout_err}, 32'd1);
    checkOutput("own_wd_grant", {29'd0, grant}, 32'd0);
    req = 3'b000;
    tick();
    checkOutput("own_wd_single", {31'd0, timeout_err}, 32'd0);
    repeat (3) tick();
    checkOutput("own_wd_idle", {31'd0, busy}, 32'd0);

    // UART never answers byte 8'h31: watchdog drops tx_enable, and no byte_done.
    uartHang = 1'b1;
    req = 3'b001;
    tick();
    applyStimulus(0, 8'h31, 1);
    repeat (99) tick();
    checkOutput("send_wd_enable_held", {31'd0, uart_tx_enable}, 32'd1);
    checkOutput("send_wd_not_yet", {31'd0, timeout_err}, 32'd0);
    tick();
    checkOutput("send_wd_enable_drop", {31'd0, uart_tx_enable}, 32'd0);
    checkOutput("send_wd_pulse", {31'd0, timeout_err}, 32'd1);
    checkOutput("send_wd_no_done", {29'd0, byte_done}, 32'd0);
    req = 3'b000;
    uartHang = 1'b0;
    tick();
    repeat (3) tick();
    checkOutput("send_wd_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a byte, with the request still held.
    req = 3'b100;
    tick();
    applyStimulus(2, 8'h55, 1);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_enable", {31'd0, uart_tx_enable}, 32'd0);
    checkOutput("midrst_grant", {29'd0, grant}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_data", {24'd0, uart_tx_data}, 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("midrst_regrant", {29'd0, grant}, 32'h4);
    req = 3'b000;
    tick();
    repeat (4) tick();
    checkOutput("midrst_idle", {31'd0, busy}, 32'd0);

    // Totals across the run.
    repeat (3) tick();
    checkOutput("total_done_sms", doneCount[0], 32'd4);
    checkOutput("total_done_dial", doneCount[1], 32'd1);
    checkOutput("total_done_answer", doneCount[2], 32'd1);
    checkOutput("total_timeouts", timeoutCount, 32'd2);
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
